// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// op codes, HI/LO direct-write codes and FSM state encoding.
package muldiv_pkg;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd1;
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MADDU = 3'd4;
    localparam logic [2:0] OP_MADD  = 3'd5;
    localparam logic [2:0] OP_MSUBU = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam logic [1:0] MDWE_HI = 2'b01;
    localparam logic [1:0] MDWE_LO = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_iter_div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock after load.
// Sign handling is done by the caller on the magnitudes it feeds in.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_part;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_part = {r_rem, r_quot[WIDTH-1]};
    assign w_ge   = (w_part >= {1'b0, r_dsr});
    assign w_sub  = w_part[WIDTH-1:0] - r_dsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_quot <= dividend;
            r_rem  <= '0;
            r_dsr  <= divisor;
            r_cnt  <= CW'(WIDTH);
        end else if (r_cnt != '0) begin
            r_rem  <= w_ge ? w_sub : w_part[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign last      = (r_cnt == CW'(1));

endmodule

// File: rtl/muldiv_iter.sv
// HI/LO multiply/divide unit: fixed-latency multiply/accumulate,
// WIDTH-cycle restoring divide plus one sign-fixup cycle.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mdwe,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MUL_LAT + 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic               r_dz_pend;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;

    logic               w_signed;
    logic               w_is_div;
    logic               w_b_zero;
    logic               w_accept;
    logic               w_div_load;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_mul;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_last;

    assign w_signed   = op_is_signed(op);
    assign w_is_div   = op_is_div(op);
    assign w_b_zero   = (b == '0);
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_div_load = w_accept && w_is_div && !w_b_zero;

    assign w_a_mag = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (w_signed && b[WIDTH-1]) ? -b : b;

    assign w_a_ext = w_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign w_b_ext = w_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign w_mul   = w_a_ext * w_b_ext;

    // The full result is formed at accept time; the counter only delays its release.
    always_comb begin
        w_mul_res = w_mul;
        case (op)
            OP_MADDU, OP_MADD: w_mul_res = {r_hi, r_lo} + w_mul;
            OP_MSUBU, OP_MSUB: w_mul_res = {r_hi, r_lo} - w_mul;
            default:           w_mul_res = w_mul;
        endcase
    end

    div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (w_div_load),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .quotient  (w_quot),
        .remainder (w_rem),
        .last      (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_dz_pend <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_prod    <= '0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_is_div) begin
                            r_dz_pend <= w_b_zero;
                            r_q_neg   <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_r_neg   <= w_signed && a[WIDTH-1];
                            // Divide by zero skips iteration and just reports in FIX.
                            r_state   <= w_b_zero ? ST_FIX : ST_DIV;
                        end else begin
                            r_prod  <= w_mul_res;
                            r_cnt   <= CW'(MUL_LAT - 1);
                            r_state <= ST_MUL;
                        end
                    end else if (mdwe == MDWE_HI) begin
                        r_hi <= a;
                    end else if (mdwe == MDWE_LO) begin
                        r_lo <= a;
                    end
                end
                ST_MUL: begin
                    if (r_cnt == '0) begin
                        {r_hi, r_lo} <= r_prod;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!r_dz_pend) begin
                        r_lo <= r_q_neg ? -w_quot : w_quot;
                        r_hi <= r_r_neg ? -w_rem : w_rem;
                    end
                    r_dz    <= r_dz_pend;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_iter;

    localparam int W   = 32;
    localparam int LAT = 5;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op    = 3'd0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic [1:0]    mdwe  = 2'b00;
    logic          busy;
    logic          done;
    logic          dz;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [W-1:0]  m_hi    = '0;
    logic [W-1:0]  m_lo    = '0;

    muldiv_iter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mdwe  (mdwe),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of one op on the given HI/LO state.
    function automatic void model(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                  input logic [31:0] hi0, input logic [31:0] lo0,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic edz, output int lat);
        logic [63:0] acc;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        acc = {hi0, lo0};
        eh  = hi0;
        el  = lo0;
        edz = 1'b0;
        lat = LAT;
        if (o == 3'd2 || o == 3'd5 || o == 3'd7)
            p = 64'(longint'($signed(xa)) * longint'($signed(xb)));
        else
            p = {32'd0, xa} * {32'd0, xb};
        case (o)
            3'd0, 3'd2: {eh, el} = p;
            3'd4, 3'd5: {eh, el} = acc + p;
            3'd6, 3'd7: {eh, el} = acc - p;
            default: begin
                if (xb == 32'd0) begin
                    edz = 1'b1;
                    lat = 1;
                end else begin
                    lat = W + 1;
                    if (o == 3'd1) begin
                        el = xa / xb;
                        eh = xa % xb;
                    end else begin
                        sa = longint'($signed(xa));
                        sb = longint'($signed(xb));
                        q  = sa / sb;
                        r  = sa % sb;
                        el = q[31:0];
                        eh = r[31:0];
                    end
                end
            end
        endcase
    endfunction

    task automatic write_hilo(input logic [1:0] sel, input logic [31:0] d);
        @(negedge clk);
        mdwe = sel;
        a    = d;
        @(posedge clk);
        #1;
        mdwe = 2'b00;
        if (sel == 2'b01) m_hi = d;
        if (sel == 2'b10) m_lo = d;
        $display("[TB] mdwe=%b data=%h -> hi=%h lo=%h", sel, d, hi, lo);
        check("mdwe_hi", hi, m_hi);
        check("mdwe_lo", lo, m_lo);
        check("mdwe_busy", busy, 1'b0);
        check("mdwe_done", done, 1'b0);
    endtask

    // mode 0: plain; 1: start+mdwe pulsed mid-op; 2: mdwe asserted alongside start
    task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb, input int mode);
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;
        int          lat;
        int          k;
        logic        held;
        logic        quiet;
        model(o, xa, xb, m_hi, m_lo, eh, el, edz, lat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = xa;
        b     = xb;
        if (mode == 2) mdwe = 2'b01;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdwe  = 2'b00;
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom);
        check("busy_start", busy, 1'b1);
        k     = 0;
        held  = 1'b1;
        quiet = 1'b1;
        while (busy === 1'b1 && k < 100) begin
            if (hi !== m_hi || lo !== m_lo) held = 1'b0;
            if (done !== 1'b0) quiet = 1'b0;
            if (mode == 1 && k == 3) begin
                start = 1'b1;
                op    = 3'd2;
                mdwe  = 2'b01;
            end else begin
                start = 1'b0;
                mdwe  = 2'b00;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        mdwe  = 2'b00;
        $display("[TB] op=%0d a=%h b=%h mode=%0d -> hi=%h lo=%h dz=%b cycles=%0d",
                 o, xa, xb, mode, hi, lo, dz, k);
        check("latency", 64'(k), 64'(lat));
        check("hold", held, 1'b1);
        check("no_early_done", quiet, 1'b1);
        check("done", done, 1'b1);
        check("dz", dz, edz);
        check("hi", hi, eh);
        check("lo", lo, el);
        m_hi = eh;
        m_lo = el;
        @(posedge clk);
        #1;
        check("done_pulse", done, 1'b0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, 0);
        run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, 0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);

        write_hilo(2'b01, 32'h00000011);
        write_hilo(2'b10, 32'h00000022);
        run_op(3'd1, 32'h00001234, 32'h00000000, 0);
        run_op(3'd3, 32'h00001234, 32'h00000000, 0);

        write_hilo(2'b01, 32'h00000000);
        write_hilo(2'b10, 32'hFFFFFFFF);
        run_op(3'd5, 32'h00000001, 32'h00000001, 0);
        write_hilo(2'b01, 32'h00000000);
        write_hilo(2'b10, 32'h00000000);
        run_op(3'd6, 32'h00000001, 32'h00000001, 0);

        run_op(3'd1, 32'd1000003, 32'd17, 1);
        run_op(3'd2, 32'hFFFFFFFD, 32'h00000007, 1);
        write_hilo(2'b10, 32'h00001234);
        run_op(3'd2, 32'h00000005, 32'hFFFFFFFE, 2);

        // Async reset in the middle of a divide.
        write_hilo(2'b01, 32'hAAAA5555);
        write_hilo(2'b10, 32'h5555AAAA);
        @(negedge clk);
        start = 1'b1;
        op    = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        $display("[TB] reset mid-divide -> busy=%b hi=%h lo=%h", busy, hi, lo);
        check("arst_busy", busy, 1'b0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        run_op(3'd0, 32'd3, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            if (sel == 2) rb = 32'($urandom_range(1, 255));
            if (sel == 3) write_hilo(2'($urandom_range(1, 2)), $urandom);
            run_op(ro, ra, rb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
